exc_sequencer: RTL and testbench

Pipeline-side exception/interrupt controller for the CP0 datapath. It arbitrates the competing event sources (EXE overflow, pending interrupt, ID reserved-instruction, ID syscall, ID eret) and picks one per cycle. It then stalls the pipeline until the MEM stage drains and issues a single commit cycle. In that commit cycle it flushes younger stages, loads the PC with the vector or EPC, and pulses the write-strobes that CP0 uses to update STATUS/CAUSE/EPC.

---
 rtl/cp0_pkg.sv | 38 +++
 rtl/exc_priority_enc.sv | 43 ++++
 rtl/exc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_exc_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 exception-sequencer definitions: exception codes, FSM and
// event-kind encodings, default vector constants and the vector helper.
package cp0_pkg;

  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_RI  = 5'h0A;
  localparam logic [4:0] EXC_OV  = 5'h0C;

  localparam logic [31:0] DEF_NORMAL_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_BOOT_BASE   = 32'hBFC0_0200;
  localparam logic [31:0] DEF_GEN_OFFSET  = 32'h0000_0180;
  localparam logic [31:0] DEF_INT_OFFSET  = 32'h0000_0200;

  localparam int unsigned SHADOW_W    = 2;
  localparam logic [1:0]  ERET_SHADOW = 2'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic {
    EXC  = 1'b0,
    ERET = 1'b1
  } kind_e;

  // Exception vector; the 32-bit add wraps on purpose.
  function automatic logic [31:0] vector_target(input logic bev, input logic use_int_offset);
    logic [31:0] base;
    logic [31:0] offs;
    base = bev ? DEF_BOOT_BASE : DEF_NORMAL_BASE;
    offs = use_int_offset ? DEF_INT_OFFSET : DEF_GEN_OFFSET;
    return base + offs;
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder for the five exception/eret request lines.
module exc_priority_enc
  import cp0_pkg::*;
(
  input  logic       exe_overflow,
  input  logic       int_req,
  input  logic       id_unknown,
  input  logic       id_syscall,
  input  logic       id_eret,
  output logic       valid,
  output logic [4:0] code,
  output kind_e      kind,
  output logic       from_exe
);

  // Highest priority first; only the overflow comes from the EXE stage.
  always_comb begin
    valid    = 1'b0;
    code     = EXC_INT;
    kind     = EXC;
    from_exe = 1'b0;
    if (exe_overflow) begin
      valid    = 1'b1;
      code     = EXC_OV;
      from_exe = 1'b1;
    end else if (int_req) begin
      valid = 1'b1;
      code  = EXC_INT;
    end else if (id_unknown) begin
      valid = 1'b1;
      code  = EXC_RI;
    end else if (id_syscall) begin
      valid = 1'b1;
      code  = EXC_SYS;
    end else if (id_eret) begin
      valid = 1'b1;
      kind  = ERET;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: arbitrate, drain MEM, then one commit cycle.
// Optional macro EXC_ERET_SHADOW_EN blocks int_req for a few cycles after eret.
module exc_sequencer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        id_eret,
  input  logic        id_syscall,
  input  logic        id_unknown,
  input  logic        exe_overflow,
  input  logic        mem_busy,
  input  logic        status_bev,
  input  logic        cause_iv,
  input  logic [31:0] epc,
  output logic        stall,
  output logic        flush_if,
  output logic        flush_id,
  output logic        flush_exe,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        exc_commit,
  output logic [4:0]  exc_code,
  output logic        eret_commit,
  output logic        busy
);

  state_e      state_r;
  state_e      state_s;
  kind_e       kind_r;
  logic [4:0]  code_r;
  logic        from_exe_r;
  logic [31:0] tgt_r;
  logic [31:0] pc_hold_r;
  logic [4:0]  code_hold_r;

  logic        int_eff_s;
  logic        enc_valid_s;
  logic [4:0]  enc_code_s;
  kind_e       enc_kind_s;
  logic        enc_from_exe_s;
  logic [31:0] enc_target_s;
  logic [31:0] commit_target_s;
  logic        stall_s;
  logic        latch_s;

`ifdef EXC_ERET_SHADOW_EN
  logic [SHADOW_W-1:0] shadow_cnt_r;

  assign int_eff_s = int_req && (shadow_cnt_r == {SHADOW_W{1'b0}});

  // Post-eret interrupt shadow: reload on eret commit, saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_cnt_r <= {SHADOW_W{1'b0}};
    end else if (state_r == COMMIT && kind_r == ERET) begin
      shadow_cnt_r <= ERET_SHADOW;
    end else if (shadow_cnt_r != {SHADOW_W{1'b0}}) begin
      shadow_cnt_r <= shadow_cnt_r - {{(SHADOW_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign int_eff_s = int_req;
`endif

  exc_priority_enc u_enc (
    .exe_overflow (exe_overflow),
    .int_req      (int_eff_s),
    .id_unknown   (id_unknown),
    .id_syscall   (id_syscall),
    .id_eret      (id_eret),
    .valid        (enc_valid_s),
    .code         (enc_code_s),
    .kind         (enc_kind_s),
    .from_exe     (enc_from_exe_s)
  );

  // Interrupt offset applies only to interrupts, and only when CAUSE.IV is set.
  assign enc_target_s = vector_target(status_bev,
                                      cause_iv && enc_kind_s == EXC && enc_code_s == EXC_INT);

  // eret takes EPC as seen in the commit cycle, not when it was accepted.
  assign commit_target_s = (kind_r == ERET) ? epc : tgt_r;

  // Next-state logic; stall rises in the very cycle an event is accepted.
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    latch_s = 1'b0;
    case (state_r)
      RUN: begin
        if (enc_valid_s) begin
          stall_s = 1'b1;
          latch_s = 1'b1;
          state_s = mem_busy ? DRAIN : COMMIT;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        stall_s = 1'b1;
        if (mem_busy) begin
          state_s = DRAIN;
        end else begin
          state_s = COMMIT;
        end
      end
      COMMIT: begin
        stall_s = 1'b1;
        state_s = RUN;
      end
      default: begin
        stall_s = 1'b0;
        state_s = RUN;
      end
    endcase
  end

  // State register, latched winner, and the values held between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= RUN;
      kind_r      <= EXC;
      code_r      <= 5'h00;
      from_exe_r  <= 1'b0;
      tgt_r       <= 32'h0000_0000;
      pc_hold_r   <= 32'h0000_0000;
      code_hold_r <= 5'h00;
    end else begin
      state_r <= state_s;
      if (latch_s) begin
        kind_r     <= enc_kind_s;
        code_r     <= enc_code_s;
        from_exe_r <= enc_from_exe_s;
        tgt_r      <= enc_target_s;
      end
      if (state_r == COMMIT) begin
        pc_hold_r <= commit_target_s;
        if (kind_r == EXC) begin
          code_hold_r <= code_r;
        end
      end
    end
  end

  // Output decode; everything reads as zero while rst is asserted.
  always_comb begin
    stall       = 1'b0;
    busy        = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    flush_exe   = 1'b0;
    pc_load     = 1'b0;
    exc_commit  = 1'b0;
    eret_commit = 1'b0;
    pc_target   = pc_hold_r;
    exc_code    = code_hold_r;
    if (rst) begin
      pc_target = 32'h0000_0000;
      exc_code  = 5'h00;
    end else begin
      stall = stall_s;
      busy  = (state_r != RUN);
      if (state_r == COMMIT) begin
        pc_load     = 1'b1;
        flush_if    = 1'b1;
        flush_id    = 1'b1;
        flush_exe   = from_exe_r;
        exc_commit  = (kind_r == EXC);
        eret_commit = (kind_r == ERET);
        pc_target   = commit_target_s;
        exc_code    = (kind_r == EXC) ? code_r : code_hold_r;
      end else begin
        pc_load = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: directed cases then random traffic.
module tb_exc_sequencer;

  logic        clk;
  logic        rst;
  logic        int_req, id_eret, id_syscall, id_unknown, exe_overflow;
  logic        mem_busy, status_bev, cause_iv;
  logic [31:0] epc;
  logic        stall, flush_if, flush_id, flush_exe, pc_load;
  logic [31:0] pc_target;
  logic        exc_commit, eret_commit, busy;
  logic [4:0]  exc_code;

  exc_sequencer dut (
    .clk(clk), .rst(rst), .int_req(int_req), .id_eret(id_eret),
    .id_syscall(id_syscall), .id_unknown(id_unknown), .exe_overflow(exe_overflow),
    .mem_busy(mem_busy), .status_bev(status_bev), .cause_iv(cause_iv), .epc(epc),
    .stall(stall), .flush_if(flush_if), .flush_id(flush_id), .flush_exe(flush_exe),
    .pc_load(pc_load), .pc_target(pc_target), .exc_commit(exc_commit),
    .exc_code(exc_code), .eret_commit(eret_commit), .busy(busy)
  );

  typedef struct packed {
    logic        is_eret;
    logic [4:0]  code;
    logic [31:0] target;
    logic        flush_exe;
  } txn_t;

  typedef struct packed {
    logic stall;
    logic busy;
    logic pc_load;
  } stat_t;

  txn_t  txn_q[$];
  stat_t stat_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: per cycle, decide what the sequencer owes the pipeline.
  initial begin : model
    bit          pending;
    bit          cur_eret;
    int          commit_at;
    int          shadow_end;
    int          win;
    logic [4:0]  codes[5];
    logic        reqs[5];
    txn_t        t;
    stat_t       s;
    logic [31:0] base;
    codes = '{5'h0C, 5'h00, 5'h0A, 5'h08, 5'h00};
    pending = 1'b0; cur_eret = 1'b0; commit_at = -1; shadow_end = -100;
    forever begin
      @(negedge clk);
      s = '0;
      if (rst) begin
        pending = 1'b0;
        commit_at = -1;
        shadow_end = -100;
        txn_q.delete();
      end else if (pending) begin
        s.stall = 1'b1;
        s.busy = 1'b1;
        if (commit_at == cyc) begin
          s.pc_load = 1'b1;
          pending = 1'b0;
          if (cur_eret) shadow_end = cyc + 2;
        end else if (commit_at < 0 && !mem_busy) begin
          commit_at = cyc + 1;
        end
      end else begin
        reqs[0] = exe_overflow;
`ifdef EXC_ERET_SHADOW_EN
        reqs[1] = int_req && (cyc > shadow_end);
`else
        reqs[1] = int_req;
`endif
        reqs[2] = id_unknown;
        reqs[3] = id_syscall;
        reqs[4] = id_eret;
        win = -1;
        for (int i = 4; i >= 0; i--) if (reqs[i]) win = i;
        if (win >= 0) begin
          pending = 1'b1;
          cur_eret = (win == 4);
          commit_at = mem_busy ? -1 : cyc + 1;
          base = status_bev ? 32'hBFC0_0200 : 32'h8000_0000;
          t.is_eret = cur_eret;
          t.code = codes[win];
          t.target = base + ((win == 1 && cause_iv) ? 32'h200 : 32'h180);
          t.flush_exe = (win == 0);
          txn_q.push_back(t);
          s.stall = 1'b1;
        end
      end
      stat_q.push_back(s);
    end
  end

  // Monitor: compares DUT outputs with the model's expectations each cycle.
  initial begin : monitor
    stat_t       s;
    txn_t        t;
    logic [31:0] last_target;
    logic [4:0]  last_code;
    last_target = 32'h0;
    last_code = 5'h0;
    forever begin
      @(negedge clk);
      #1;
      if (stat_q.size() == 0) begin
        chk("stat_queue_empty", 32'd0, 32'd1);
      end else begin
        s = stat_q.pop_front();
        chk("stall", {31'd0, stall}, {31'd0, s.stall});
        chk("busy", {31'd0, busy}, {31'd0, s.busy});
        chk("pc_load", {31'd0, pc_load}, {31'd0, s.pc_load});
        if (rst) begin
          last_target = 32'h0;
          last_code = 5'h0;
          chk("rst_pc_target", pc_target, 32'h0);
          chk("rst_exc_code", {27'd0, exc_code}, 32'h0);
        end else if (s.pc_load) begin
          if (txn_q.size() == 0) begin
            chk("txn_queue_empty", 32'd0, 32'd1);
          end else begin
            t = txn_q.pop_front();
            if (t.is_eret) t.target = epc;
            else t.code = t.code;
            chk("commit_flush_if_id", {30'd0, flush_if, flush_id}, 32'd3);
            chk("commit_flush_exe", {31'd0, flush_exe}, {31'd0, t.flush_exe});
            chk("commit_exc", {31'd0, exc_commit}, {31'd0, ~t.is_eret});
            chk("commit_eret", {31'd0, eret_commit}, {31'd0, t.is_eret});
            chk("commit_target", pc_target, t.target);
            chk("commit_code", {27'd0, exc_code}, {27'd0, t.is_eret ? last_code : t.code});
            last_target = t.target;
            if (!t.is_eret) last_code = t.code;
          end
        end else begin
          chk("idle_strobes", {27'd0, flush_if, flush_id, flush_exe, exc_commit, eret_commit}, 32'd0);
          chk("held_target", pc_target, last_target);
          chk("held_code", {27'd0, exc_code}, {27'd0, last_code});
        end
      end
    end
  end

  task automatic step(input logic ov, input logic ir, input logic un, input logic sy,
                      input logic er, input logic mb, input logic bev, input logic iv,
                      input logic [31:0] e, input logic r);
    exe_overflow = ov; int_req = ir; id_unknown = un; id_syscall = sy; id_eret = er;
    mem_busy = mb; status_bev = bev; cause_iv = iv; epc = e; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin : driver
    exe_overflow = 1'b0; int_req = 1'b0; id_unknown = 1'b0; id_syscall = 1'b0;
    id_eret = 1'b0; mem_busy = 1'b0; status_bev = 1'b0; cause_iv = 1'b0;
    epc = 32'h0; rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(2);
    // Overflow, no drain, normal base.
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(3);
    // Interrupt beats syscall; vectored interrupt from boot base.
    step(0, 1, 0, 1, 0, 0, 1, 1, 32'h0, 0);
    idle(3);
    // Reserved instruction behind a three-cycle MEM stall.
    step(0, 0, 1, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(3);
    // eret then a persistent interrupt request.
    step(0, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0024, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0024, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0024, 0);
    idle(3);
    // Reset while draining.
    step(0, 0, 1, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1);
    idle(4);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 40,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom, $urandom_range(0, 199) == 0);
    end
    idle(6);
    @(negedge clk);
    #2;
    chk("txn_queue_drained", txn_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
